barrel_shifter_pipe: RTL
========================

BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

Interface
REQ-001 Parameter WIDTH, default 8: data width; SHALL be a power of two, 4 to 64 inclusive.
REQ-002 Parameter LOG2W, default 3: shift-amount width; SHALL equal log2(WIDTH) and is checked at elaboration.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 in_valid  input  1: in_data/in_amt/in_mode hold a beat.
REQ-006 in_ready  output  1: block accepts a beat this cycle.
REQ-007 in_data  input  WIDTH: operand.
REQ-008 in_amt  input  LOG2W: shift distance, 0..WIDTH-1.
REQ-009 in_mode  input  2: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
REQ-010 out_valid  output  1: out_data holds a result.
REQ-011 out_ready  input  1: consumer accepts out_data this cycle.
REQ-012 out_data  output  WIDTH: shifted result.

Function
REQ-013 A beat SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-014 The pipeline SHALL have exactly LOG2W register stages; stage k (k=0..LOG2W-1) applies a shift of 2^k when amt bit k is 1, otherwise passes data unchanged.
REQ-015 Each stage register SHALL carry data, remaining amt bits, mode and a valid bit.
REQ-016 Each stage's per-bit logic SHALL be a 4:1 mux selected by mode: SLL fill 0 from LSB; SRL fill 0 from MSB; SRA fill with the operand's original MSB; ROL wrap bits leaving the MSB into the LSB.
REQ-017 SRA fill SHALL use the sign bit captured at acceptance, not the partially shifted stage value.
REQ-018 Latency: a beat accepted on edge N SHALL appear on out_data with out_valid=1 after edge N+LOG2W-1; with no stalls, throughput is one beat per cycle.
REQ-019 Advance enable adv = ~out_valid | out_ready; when adv=1 all stages shift forward one position on the edge; when adv=0 all stage registers, including valid bits, hold.
REQ-020 in_ready SHALL equal adv, combinationally.
REQ-021 When adv=1 and no beat is accepted, a bubble (valid=0) SHALL enter stage 0.
REQ-022 in_amt=0 SHALL return in_data unchanged in every mode.
REQ-023 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 Results SHALL leave in acceptance order; no beat is dropped or duplicated.
REQ-025 in_data/in_amt/in_mode SHALL be ignored when in_valid=0 or in_ready=0.
REQ-026 Simultaneous out_ready=1 and in_valid=1 with a full pipeline: the output beat retires and the input beat is accepted on the same edge.
REQ-027 No combinational path SHALL exist from in_data/in_amt/in_mode to out_data; out_data is driven from the last stage register.

Reset
REQ-028 While rst=1 on a rising edge, all stage valid bits and out_valid SHALL clear to 0 and out_data to 0, regardless of other inputs.
REQ-029 A beat presented during reset SHALL NOT be accepted; in-flight beats are discarded.
REQ-030 in_ready SHALL be 1 on the first cycle after rst deasserts.
REQ-031 After reset, stage data registers need not be cleared, except that out_data is 0.

Verification
REQ-032 WIDTH=8, in_data=8'h96, in_amt=3, modes 00/01/10/11 sent back to back with out_ready=1 -> outputs 8'hB0, 8'h12, 8'hF2, 8'hB4 in order, the first after 3 edges, then one per cycle.
REQ-033 in_amt=0, in_data=8'hA5, all four modes -> 8'hA5 each.
REQ-034 in_data=8'h80, in_amt=7: SRA -> 8'hFF; SRL -> 8'h01; ROL -> 8'h40. in_data=8'h01, in_amt=7, SLL -> 8'h80.
REQ-035 Stream of 16 random beats with out_ready held 0 for 5 cycles mid-stream -> in_ready=0 while out_valid=1 and out_ready=0; out_data held stable; all 16 results correct and in order.
REQ-036 rst=1 asserted for one edge with 3 beats in flight -> out_valid=0 and out_data=0 next cycle; no stale beat appears afterwards; in_ready=1 after release.
REQ-037 Scoreboard vs reference model, WIDTH=16 and 32, random modes, amounts and out_ready pattern (10k beats) -> zero mismatches.

Source files
------------

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, with a
// valid/ready handshake on both sides and a global advance enable.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input beat present on in_data/in_amt/in_mode
//   in_ready   block accepts a beat this cycle (combinational, = advance)
//   in_data    operand, WIDTH bits
//   in_amt     shift distance, LOG2W bits
//   in_mode    00 SLL, 01 SRL, 10 SRA, 11 ROL
//   out_valid  out_data holds a result
//   out_ready  consumer accepts out_data this cycle
//   out_data   shifted result, driven straight from the last stage register
module barrel_shifter_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LOG2W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_amt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int unsigned LAST   = LOG2W - 1;
  localparam int unsigned AMT_RW = LOG2W - 1;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;

  // Elaboration-time parameter sanity check.
  if (WIDTH < 4 || WIDTH > 64 || WIDTH != (32'd1 << LOG2W)) begin : g_bad_param
    $error("barrel_shifter_pipe: WIDTH must be a power of two in 4..64 and LOG2W = log2(WIDTH)");
  end

  // Fixed-distance shift for one stage; sh is a constant per call site.
  // SRA fill uses the sign captured at acceptance, not the current MSB.
  function automatic logic [WIDTH-1:0] shift_stage(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       mode,
    input logic             sign,
    input int unsigned      sh
  );
    logic [WIDTH-1:0] fill;
    fill = {WIDTH{sign}} << (WIDTH - sh);
    case (mode)
      MODE_SLL: return d << sh;
      MODE_SRL: return d >> sh;
      MODE_SRA: return fill | (d >> sh);
      default:  return (d << sh) | (d >> (WIDTH - sh));
    endcase
  endfunction

  // Stage inputs (from the port for stage 0, else from the previous register).
  logic [WIDTH-1:0] src_data  [LOG2W];
  logic [LOG2W-1:0] src_amt   [LOG2W];
  logic [1:0]       src_mode  [LOG2W];
  logic             src_sign  [LOG2W];
  logic             src_valid [LOG2W];
  logic [WIDTH-1:0] stage_d   [LOG2W];

  // Stage registers; amt/mode/sign are not needed past the last stage.
  logic [WIDTH-1:0]  data_q  [LOG2W];
  logic              valid_q [LOG2W];
  logic [AMT_RW-1:0] amt_q   [LAST];
  logic [1:0]        mode_q  [LAST];
  logic              sign_q  [LAST];

  logic adv;

  assign adv       = ~valid_q[LAST] | out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[LAST];
  assign out_data  = data_q[LAST];

  for (genvar k = 0; k < LOG2W; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign src_data[k]  = in_data;
      assign src_amt[k]   = in_amt;
      assign src_mode[k]  = in_mode;
      assign src_sign[k]  = in_data[WIDTH-1];
      assign src_valid[k] = in_valid;
    end else begin : g_body
      // Remaining amt bits are kept right-aligned so bit 0 is always "this stage".
      assign src_data[k]  = data_q[k-1];
      assign src_amt[k]   = {1'b0, amt_q[k-1]};
      assign src_mode[k]  = mode_q[k-1];
      assign src_sign[k]  = sign_q[k-1];
      assign src_valid[k] = valid_q[k-1];
    end

    assign stage_d[k] = src_amt[k][0]
                      ? shift_stage(src_data[k], src_mode[k], src_sign[k], (32'd1 << k))
                      : src_data[k];
  end

  // The last stage consumes only bit 0 of its amount field.
  logic unused_amt;
  assign unused_amt = ^src_amt[LAST][LOG2W-1:1];

  // Stage registers: all advance together on adv, all hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LOG2W; i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
      end
      for (int unsigned i = 0; i < LAST; i++) begin
        amt_q[i]  <= '0;
        mode_q[i] <= '0;
        sign_q[i] <= 1'b0;
      end
    end else if (adv) begin
      for (int unsigned i = 0; i < LOG2W; i++) begin
        valid_q[i] <= src_valid[i];
        data_q[i]  <= stage_d[i];
      end
      for (int unsigned i = 0; i < LAST; i++) begin
        amt_q[i]  <= src_amt[i][LOG2W-1:1];
        mode_q[i] <= src_mode[i];
        sign_q[i] <= src_sign[i];
      end
    end
  end

endmodule
